// File: rtl/hub75_scan_scheduler.sv
// hub75_scan_scheduler: HUB75 bit-plane (BCM) scan sequencer driving shift, latch and output-enable timing
module hub75_scan_scheduler #(
    parameter int unsigned COLS       = 64,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned BPC        = 4,
    parameter int unsigned BASE_ON    = 16,
    parameter int unsigned COL_BITS   = 6,
    parameter int unsigned ROW_BITS   = 5,
    parameter int unsigned PLANE_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  enable,
    output logic [COL_BITS-1:0]   rd_col,
    output logic [ROW_BITS-1:0]   rd_row,
    output logic [PLANE_BITS-1:0] rd_plane,
    output logic                  pix_load,
    output logic                  h75_clk,
    output logic                  h75_lat,
    output logic                  h75_oe_n,
    output logic [ROW_BITS-1:0]   h75_addr,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int unsigned CNT_W = $clog2((BASE_ON << (BPC - 1)) + 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY} state_t;

    state_t                state_q, state_d;
    logic [COL_BITS-1:0]   rd_col_q, rd_col_d;
    logic [ROW_BITS-1:0]   rd_row_q, rd_row_d;
    logic [PLANE_BITS-1:0] rd_plane_q, rd_plane_d;
    logic [ROW_BITS-1:0]   cur_row_q, cur_row_d;
    logic [PLANE_BITS-1:0] cur_plane_q, cur_plane_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pix_load_q, pix_load_d;
    logic                  h75_clk_q, h75_clk_d;
    logic                  h75_lat_q, h75_lat_d;
    logic                  h75_oe_n_q, h75_oe_n_d;
    logic [ROW_BITS-1:0]   h75_addr_q, h75_addr_d;
    logic                  frame_done_q, frame_done_d;

    logic last_col, last_plane, last_row, last_cnt;

    assign last_col   = rd_col_q == COL_BITS'(COLS - 1);
    assign last_plane = rd_plane_q == PLANE_BITS'(BPC - 1);
    assign last_row   = rd_row_q == ROW_BITS'(ROWS - 1);
    assign last_cnt   = cnt_q == CNT_W'(1);

    // Next-state and next-output logic; everything advances only on tick, pulses self-clear every clk
    always_comb begin
        state_d      = state_q;
        rd_col_d     = rd_col_q;
        rd_row_d     = rd_row_q;
        rd_plane_d   = rd_plane_q;
        cur_row_d    = cur_row_q;
        cur_plane_d  = cur_plane_q;
        cnt_d        = cnt_q;
        pix_load_d   = 1'b0;
        h75_clk_d    = h75_clk_q;
        h75_lat_d    = h75_lat_q;
        h75_oe_n_d   = h75_oe_n_q;
        h75_addr_d   = h75_addr_q;
        frame_done_d = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    state_d = enable ? SHIFT_LO : IDLE;
                end
                SHIFT_LO: begin
                    h75_clk_d  = 1'b0;
                    pix_load_d = 1'b1;
                    state_d    = SHIFT_HI;
                end
                SHIFT_HI: begin
                    h75_clk_d = 1'b1;
                    rd_col_d  = last_col ? '0 : rd_col_q + 1'b1;
                    state_d   = last_col ? LATCH : SHIFT_LO;
                    if (last_col) begin
                        cur_row_d   = rd_row_q;
                        cur_plane_d = rd_plane_q;
                        rd_plane_d  = last_plane ? '0 : rd_plane_q + 1'b1;
                        rd_row_d    = !last_plane ? rd_row_q : (last_row ? '0 : rd_row_q + 1'b1);
                    end
                end
                LATCH: begin
                    h75_clk_d  = 1'b0;
                    h75_lat_d  = 1'b1;
                    h75_addr_d = cur_row_q;
                    cnt_d      = CNT_W'(BASE_ON) << cur_plane_q;
                    state_d    = DISPLAY;
                end
                DISPLAY: begin
                    h75_lat_d    = 1'b0;
                    cnt_d        = cnt_q - 1'b1;
                    h75_oe_n_d   = last_cnt;
                    frame_done_d = last_cnt && cur_row_q == ROW_BITS'(ROWS - 1)
                                   && cur_plane_q == PLANE_BITS'(BPC - 1);
                    state_d      = !last_cnt ? DISPLAY : (enable ? SHIFT_LO : IDLE);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_col_q     <= '0;
            rd_row_q     <= '0;
            rd_plane_q   <= '0;
            cur_row_q    <= '0;
            cur_plane_q  <= '0;
            cnt_q        <= '0;
            pix_load_q   <= 1'b0;
            h75_clk_q    <= 1'b0;
            h75_lat_q    <= 1'b0;
            h75_oe_n_q   <= 1'b1;
            h75_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_col_q     <= rd_col_d;
            rd_row_q     <= rd_row_d;
            rd_plane_q   <= rd_plane_d;
            cur_row_q    <= cur_row_d;
            cur_plane_q  <= cur_plane_d;
            cnt_q        <= cnt_d;
            pix_load_q   <= pix_load_d;
            h75_clk_q    <= h75_clk_d;
            h75_lat_q    <= h75_lat_d;
            h75_oe_n_q   <= h75_oe_n_d;
            h75_addr_q   <= h75_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_col     = rd_col_q;
    assign rd_row     = rd_row_q;
    assign rd_plane   = rd_plane_q;
    assign pix_load   = pix_load_q;
    assign h75_clk    = h75_clk_q;
    assign h75_lat    = h75_lat_q;
    assign h75_oe_n   = h75_oe_n_q;
    assign h75_addr   = h75_addr_q;
    assign frame_done = frame_done_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// tb_hub75_scan_scheduler: scoreboard bench for the HUB75 scan scheduler (4 cols, 2 rows, 2 planes, base 3)
module tb_hub75_scan_scheduler;
    localparam int COLS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] rd_col;
    logic [0:0] rd_row;
    logic [0:0] rd_plane;
    logic       pix_load, h75_clk, h75_lat, h75_oe_n, frame_done, busy;
    logic [0:0] h75_addr;

    hub75_scan_scheduler #(
        .COLS(4), .ROWS(2), .BPC(2), .BASE_ON(3), .COL_BITS(2), .ROW_BITS(1), .PLANE_BITS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .rd_col(rd_col), .rd_row(rd_row), .rd_plane(rd_plane), .pix_load(pix_load),
        .h75_clk(h75_clk), .h75_lat(h75_lat), .h75_oe_n(h75_oe_n), .h75_addr(h75_addr),
        .frame_done(frame_done), .busy(busy)
    );

    int n_assert = 0;
    int n_fail = 0;
    int q_load[$];
    int q_addr[$];
    int q_oe[$];
    int n_hclk = 0, n_lat = 0, n_fd = 0, oe_ticks = 0, last_col = 0;
    bit tick_run = 1'b0, tick_s = 1'b0, prev_oe = 1'b1, prev_lat = 1'b0, prev_hclk = 1'b0;

    always #5 clk = ~clk;

    // Tick every second clk while running, changed just after the rising edge
    initial forever begin
        @(posedge clk);
        #1;
        tick = tick_run ? !tick : 1'b0;
    end

    // Remember whether the edge just taken was a tick edge
    always @(posedge clk) tick_s = tick;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: pops scoreboard entries as the DUT produces loads, latches and OE windows
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_oe = 1'b1;
            prev_lat = 1'b0;
            prev_hclk = 1'b0;
            oe_ticks = 0;
        end else begin
            if (pix_load) begin
                check("load_expected", int'(q_load.size() > 0), 1);
                if (q_load.size() > 0) begin
                    int e;
                    e = q_load.pop_front();
                    check("load_pos", rd_row * 100 + rd_plane * 10 + rd_col, e);
                    last_col = e % 10;
                end
            end
            if (h75_clk && !prev_hclk) begin
                n_hclk++;
                check("col_step", rd_col, (last_col + 1) % COLS);
            end
            if (h75_lat) n_lat++;
            if (h75_lat && !prev_lat) begin
                check("latch_expected", int'(q_addr.size() > 0), 1);
                if (q_addr.size() > 0) check("latch_addr", h75_addr, q_addr.pop_front());
                check("latch_oe_n", h75_oe_n, 1);
            end
            if (frame_done) n_fd++;
            if (tick_s && (!prev_oe || !h75_oe_n)) oe_ticks++;
            if (!prev_oe && h75_oe_n) begin
                check("oe_expected", int'(q_oe.size() > 0), 1);
                if (q_oe.size() > 0) check("oe_ticks", oe_ticks, q_oe.pop_front());
                oe_ticks = 0;
            end
            prev_oe = h75_oe_n;
            prev_lat = h75_lat;
            prev_hclk = h75_clk;
        end
    end

    initial begin
        int t, pl;
        // Reset held with tick and enable active
        enable = 1'b1;
        tick_run = 1'b1;
        pl = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pl += int'(pix_load);
        end
        check("rst_pix_load", pl, 0);
        check("rst_oe_n", h75_oe_n, 1);
        check("rst_clk", h75_clk, 0);
        check("rst_lat", h75_lat, 0);
        check("rst_addr", h75_addr, 0);
        check("rst_rd", rd_row * 100 + rd_plane * 10 + rd_col, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        // Two full frames plus row 0 of a third
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < (f == 2 ? 1 : 2); r++)
                for (int p = 0; p < 2; p++) begin
                    for (int c = 0; c < COLS; c++) q_load.push_back(r * 100 + p * 10 + c);
                    q_addr.push_back(r);
                    q_oe.push_back(3 << p);
                end
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("busy_rise", busy, 1);
        t = 0;
        while (!frame_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("frame1_clks", t, 108);
        @(negedge clk);
        check("frame1_done_count", n_fd, 1);
        check("frame1_clk_rises", n_hclk, 16);
        check("frame1_lat_clks", n_lat, 8);
        t = 1;
        while (!frame_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("frame2_clks", t, 108);
        @(negedge clk);
        check("frame2_done_count", n_fd, 2);
        check("frame2_clk_rises", n_hclk, 32);
        // Drop enable while row 0 plane 1 is shifting
        for (int i = 0; i < 80 && !(pix_load && rd_plane == 1'b1); i++) @(negedge clk);
        check("p1_shift_seen", int'(pix_load && rd_plane == 1'b1), 1);
        enable = 1'b0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("stop_busy", busy, 0);
        check("stop_oe_n", h75_oe_n, 1);
        check("stop_rd_row", rd_row, 1);
        check("stop_rd_plane", rd_plane, 0);
        check("stop_rd_col", rd_col, 0);
        check("stop_frame_done_count", n_fd, 2);
        check("stop_load_q", q_load.size(), 0);
        check("stop_addr_q", q_addr.size(), 0);
        check("stop_oe_q", q_oe.size(), 0);
        // Resume: row 1 plane 0 must follow
        for (int c = 0; c < COLS; c++) q_load.push_back(100 + c);
        q_addr.push_back(1);
        q_oe.push_back(3);
        enable = 1'b1;
        for (int i = 0; i < 60 && h75_oe_n; i++) @(negedge clk);
        check("resume_oe_low", h75_oe_n, 0);
        // Freeze ticks mid-display
        tick_run = 1'b0;
        repeat (2) @(negedge clk);
        repeat (100) @(negedge clk);
        check("pause_oe_n", h75_oe_n, 0);
        check("pause_state", {h75_clk, h75_lat, h75_addr, busy, pix_load}, 5'b00110);
        check("pause_rd", rd_row * 100 + rd_plane * 10 + rd_col, 110);
        for (int c = 0; c < COLS; c++) q_load.push_back(110 + c);
        q_addr.push_back(1);
        tick_run = 1'b1;
        for (int i = 0; i < 30 && !h75_oe_n; i++) @(negedge clk);
        check("resume_oe_high", h75_oe_n, 1);
        for (int i = 0; i < 60 && h75_oe_n; i++) @(negedge clk);
        check("p1_oe_low", h75_oe_n, 0);
        // One-clk reset in the middle of display
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("mid_rst_oe_n", h75_oe_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", h75_addr, 0);
        check("mid_rst_rd", rd_row * 100 + rd_plane * 10 + rd_col, 0);
        check("mid_rst_lat_clk", {h75_lat, h75_clk}, 0);
        rst_n = 1'b1;
        check("end_load_q", q_load.size(), 0);
        check("end_addr_q", q_addr.size(), 0);
        check("end_oe_q", q_oe.size(), 0);
        check("end_frame_done_count", n_fd, 2);
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
